// File: rtl/pipelined_slice_adder.sv
// Pipelined add/subtract unit resolving one SLICE-bit ripple slice per stage.
// Optional saturation on signed overflow is enabled by defining PIPE_ADDER_SAT_EN.
module pipelined_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;
  localparam int LAST   = STAGES - 1;

  generate
    if (WIDTH % SLICE != 0) begin : g_width_check
      $error("pipelined_slice_adder: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  // acc holds operand A with its low slices progressively overwritten by sums
  logic             vld       [STAGES];
  logic             cry       [STAGES];
  logic [WIDTH-1:0] acc       [STAGES];
  logic [WIDTH-1:0] bop       [STAGES];
  logic [SLICE-1:0] slice_sum [STAGES];
  logic             slice_cy  [STAGES];
  logic [WIDTH-1:0] next_acc  [STAGES];

  logic             en;
  logic             a_msb;
  logic             b_msb;
  logic             ovf_next;
  logic [WIDTH-1:0] s_next;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      {slice_cy[k], slice_sum[k]} = {1'b0, acc[k][k*SLICE +: SLICE]}
                                  + {1'b0, bop[k][k*SLICE +: SLICE]}
                                  + {{SLICE{1'b0}}, cry[k]};
      next_acc[k]                  = acc[k];
      next_acc[k][k*SLICE +: SLICE] = slice_sum[k];
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and the operand MSBs
  assign a_msb    = acc[LAST][WIDTH-1];
  assign b_msb    = bop[LAST][WIDTH-1];
  assign ovf_next = a_msb ^ b_msb ^ slice_sum[LAST][SLICE-1] ^ slice_cy[LAST];

`ifdef PIPE_ADDER_SAT_EN
  logic sat_p [STAGES];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < STAGES; k++) sat_p[k] <= 1'b0;
    end else if (en) begin
      sat_p[0] <= sat;
      for (int k = 1; k < STAGES; k++) sat_p[k] <= sat_p[k-1];
    end
  end

  // Overflow implies equal operand signs, so a_msb tells the clamp direction
  always_comb begin
    s_next = next_acc[LAST];
    if (sat_p[LAST] && ovf_next)
      s_next = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign s_next = next_acc[LAST];
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        cry[k] <= 1'b0;
        acc[k] <= '0;
        bop[k] <= '0;
      end
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      vld[0] <= in_valid;
      acc[0] <= a;
      bop[0] <= sub ? ~b : b;
      cry[0] <= sub ? 1'b1 : c_in;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        cry[k] <= slice_cy[k-1];
        acc[k] <= next_acc[k-1];
        bop[k] <= bop[k-1];
      end
      out_valid <= vld[LAST];
      s         <= s_next;
      c_out     <= slice_cy[LAST];
      ovf       <= ovf_next;
    end
  end

endmodule
